// File: rtl/mult_seq_4bit.sv
// Sequential unsigned shift-and-add multiplier.
// Retires one partial-product step per clock and has a fixed latency of WIDTH clocks.
//
// state  | meaning
// -------+----------------------------------------------------------------
// S_IDLE | waiting for start; product holds the last result
// S_RUN  | one add/shift step per edge; busy=1
// S_DONE | single-cycle done pulse; a start here is accepted as in idle
module mult_seq_4bit #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A_input,
    input  logic [WIDTH-1:0]     B_input,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WIDTH - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [2*WIDTH:0]       r_p;
    logic [WIDTH-1:0]       r_mcand;
    logic [CNT_W-1:0]       r_count;
    logic [2*WIDTH-1:0]     r_product;

    logic                   w_accept;
    logic                   w_last;
    logic [WIDTH:0]         w_sum;
    logic [WIDTH:0]         w_upper;
    logic [2*WIDTH:0]       w_shifted;

    // start is only honoured when not busy, so IDLE and DONE both accept
    assign w_accept  = start && (r_state != S_RUN);
    assign w_last    = (r_count == LP_LAST);

    // The adder is WIDTH+1 bits wide so its carry lands in the top of P
    // and is shifted down into the product instead of being dropped.
    assign w_sum     = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
    assign w_upper   = r_p[0] ? w_sum : r_p[2*WIDTH:WIDTH];
    assign w_shifted = {1'b0, w_upper, r_p[WIDTH-1:1]};

    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign product = r_product;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, add/shift steps, step counter and result register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p       <= '0;
            r_mcand   <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mcand <= A_input;
            r_p     <= {{(WIDTH+1){1'b0}}, B_input};
            r_count <= '0;
        end else if (r_state == S_RUN) begin
            r_p <= w_shifted;
            if (w_last) begin
                r_product <= w_shifted[2*WIDTH-1:0];
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mult_seq_4bit.sv
// Directed bench for mult_seq_4bit with a queue of expected products.
module tb_mult_seq_4bit;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [3:0] A_input;
    logic [3:0] B_input;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int         n_checks;
    int         n_errors;
    logic [7:0] sb_q[$];
    logic [7:0] exp_hold;
    logic [7:0] last_obs;

    mult_seq_4bit #(.WIDTH(4), .CNT_W(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .A_input (A_input),
        .B_input (B_input),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one request and follows it to its DONE cycle.
    // hold keeps start high during RUN, where it must be ignored.
    task automatic op(input logic [3:0] a, input logic [3:0] b, input bit hold);
        logic [7:0] e;
        start   = 1'b1;
        A_input = a;
        B_input = b;
        sb_q.push_back(8'(a) * 8'(b));
        for (int j = 0; j <= 4; j++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (j < 4) begin
                A_input = 4'($urandom_range(15));
                B_input = 4'($urandom_range(15));
                chk("busy_run", 16'(busy), 16'd1);
                chk("done_run", 16'(done), 16'd0);
                chk("prod_hold_run", 16'(product), 16'(exp_hold));
            end else begin
                chk("busy_done", 16'(busy), 16'd0);
                chk("done_pulse", 16'(done), 16'd1);
                if (sb_q.size() == 0) begin
                    chk("sb_empty", 16'd1, 16'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("product", 16'(product), 16'(e));
                    exp_hold = e;
                end
                last_obs = product;
            end
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_busy", 16'(busy), 16'd0);
            chk("idle_done", 16'(done), 16'd0);
            chk("idle_prod", 16'(product), 16'(exp_hold));
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_hold = 8'h00;
        last_obs = 8'h00;
        reset_n  = 1'b0;
        start    = 1'b0;
        A_input  = 4'd0;
        B_input  = 4'd0;

        #1;
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_prod", 16'(product), 16'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // 7*3, then the result must stay put while idle
        op(4'd7, 4'd3, 1'b0);
        idle_check(10);

        // carry retention in the step adder
        op(4'd15, 4'd15, 1'b0);
        idle_check(1);

        // zero operands still take all four steps
        op(4'd0, 4'd9, 1'b0);
        idle_check(1);
        op(4'd9, 4'd0, 1'b0);
        idle_check(1);

        // start held high: ignored while busy, re-accepted in each DONE cycle
        op(4'd5, 4'd6, 1'b1);
        op(4'd3, 4'd13, 1'b1);
        op(4'd10, 4'd14, 1'b1);
        start = 1'b0;
        idle_check(2);

        // reset two cycles into a run: immediate clear, no done afterwards
        start   = 1'b1;
        A_input = 4'd12;
        B_input = 4'd11;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 16'(busy), 16'd0);
        chk("midrst_done", 16'(done), 16'd0);
        chk("midrst_prod", 16'(product), 16'd0);
        exp_hold = 8'h00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle_check(6);
        op(4'd12, 4'd11, 1'b0);
        idle_check(1);

        // every operand pair, back to back
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                op(4'(a), 4'(b), 1'b0);
                if (a != 0) chk("div_xcheck", 16'(last_obs) / 16'(a), 16'(b));
            end
        end
        idle_check(2);
        chk("sb_drained", 16'(sb_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
